// File: rtl/e1_seq_gen_if.sv
// Handshake/symbol bundle between a stimulus consumer (master) and e1_seq_gen (slave).
interface e1_seq_gen_if #(
  parameter int unsigned W = 4
) ();
  logic         start;
  logic [W-1:0] len;
  logic [W-1:0] reps;
  logic         A;
  logic         B;
  logic         y_exp;
  logic         busy;
  logic         done;
  logic [W-1:0] frames_left;

  modport master (
    output start, len, reps,
    input  A, B, y_exp, busy, done, frames_left
  );

  modport slave (
    input  start, len, reps,
    output A, B, y_exp, busy, done, frames_left
  );
endinterface

// File: rtl/e1_seq_gen.sv
// Stimulus generator for the exercise-1 Mealy detector: emits `reps` frames of
// ARM, SET, `len` x FIRE, GAP and the Y value a correct detector must produce.
module e1_seq_gen #(
  parameter int unsigned W = 4
) (
  input logic          clk,
  input logic          rst,
  e1_seq_gen_if.slave  bus
);

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StSet,
    StFire,
    StGap,
    StNull
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] len_q, len_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] frames_q, frames_d;

  // State and datapath registers, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      len_q    <= '0;
      cnt_q    <= '0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      frames_q <= frames_d;
    end
  end

  // Next-state logic; start/len/reps only ever reach registers, never outputs.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    frames_d = frames_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.reps != '0) begin
            len_d    = bus.len;
            frames_d = bus.reps;
            cnt_d    = '0;
            state_d  = StArm;
          end else begin
            state_d = StNull;
          end
        end
      end
      StArm: state_d = StSet;
      StSet: state_d = (len_q != '0) ? StFire : StGap;
      StFire: begin
        cnt_d = cnt_q + W'(1);
        // len_q is non-zero here, so len_q - 1 cannot underflow.
        if (cnt_q == len_q - W'(1)) begin
          state_d = StGap;
        end
      end
      StGap: begin
        frames_d = frames_q - W'(1);
        if (frames_q == W'(1)) begin
          state_d = StIdle;
        end else begin
          cnt_d   = '0;
          state_d = StArm;
        end
      end
      StNull:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded purely from registered state.
  always_comb begin
    bus.A           = (state_q == StArm) || (state_q == StFire);
    bus.B           = (state_q == StSet) || (state_q == StFire);
    bus.y_exp       = (state_q == StFire);
    bus.busy        = (state_q != StIdle);
    bus.done        = (state_q == StNull) || ((state_q == StGap) && (frames_q == W'(1)));
    bus.frames_left = frames_q;
  end

endmodule

// File: tb/tb_e1_seq_gen.sv
// Self-checking bench for e1_seq_gen: directed scenarios plus random traffic,
// checked cycle by cycle against an arithmetic model of the frame schedule.
module tb_e1_seq_gen;
  localparam int unsigned W = 4;

  logic clk;
  logic rst;
  e1_seq_gen_if #(.W(W)) bus ();

  e1_seq_gen #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: offset k into an accepted transfer plus its latched parameters.
  bit m_active = 1'b0;
  int m_k = 0;
  int m_len = 0;
  int m_reps = 0;
  int m_total = 0;

  int busy_cnt = 0;
  int y_cnt = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, advance the model at the edge, then compare.
  task automatic step(input logic r, input logic s, input int l, input int n);
    logic ea, eb, ey, ebusy, edone;
    int efl, f, p;
    rst       = r;
    bus.start = s;
    bus.len   = l[W-1:0];
    bus.reps  = n[W-1:0];
    @(posedge clk);
    if (r) begin
      m_active = 1'b0;
    end else if (m_active) begin
      if (m_k == m_total) m_active = 1'b0;
      else m_k++;
    end else if (s) begin
      m_active = 1'b1;
      m_k      = 1;
      m_len    = l;
      m_reps   = n;
      m_total  = (n == 0) ? 1 : n * (l + 3);
    end
    ea = 0; eb = 0; ey = 0; ebusy = 0; edone = 0; efl = 0;
    if (m_active) begin
      ebusy = 1;
      edone = (m_k == m_total);
      if (m_reps != 0) begin
        f   = (m_k - 1) / (m_len + 3);
        p   = (m_k - 1) % (m_len + 3);
        efl = m_reps - f;
        if (p == 0) ea = 1;
        else if (p == 1) eb = 1;
        else if (p != m_len + 2) begin
          ea = 1; eb = 1; ey = 1;
        end
      end
    end
    #1;
    check("A", 32'(bus.A), 32'(ea));
    check("B", 32'(bus.B), 32'(eb));
    check("y_exp", 32'(bus.y_exp), 32'(ey));
    check("busy", 32'(bus.busy), 32'(ebusy));
    check("done", 32'(bus.done), 32'(edone));
    check("frames_left", 32'(bus.frames_left), 32'(efl));
    if (bus.busy === 1'b1) busy_cnt++;
    if (bus.y_exp === 1'b1) y_cnt++;
    if (bus.done === 1'b1) done_cnt++;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, 0, 0);
  endtask

  task automatic clear_counts();
    busy_cnt = 0;
    y_cnt    = 0;
    done_cnt = 0;
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.len   = '0;
    bus.reps  = '0;

    // Reset held with start asserted: nothing may begin.
    step(1'b1, 1'b1, 2, 1);
    step(1'b1, 1'b1, 2, 1);
    idle(2);

    // Single frame, len=2.
    step(1'b0, 1'b1, 2, 1);
    idle(6);

    // Four frames of len=3.
    clear_counts();
    step(1'b0, 1'b1, 3, 4);
    idle(26);
    check("multi_busy_cycles", 32'(busy_cnt), 32'd24);
    check("multi_fire_cycles", 32'(y_cnt), 32'd12);
    check("multi_done_pulses", 32'(done_cnt), 32'd1);

    // len=0: frames without FIRE.
    clear_counts();
    step(1'b0, 1'b1, 0, 2);
    idle(7);
    check("len0_fire_cycles", 32'(y_cnt), 32'd0);
    check("len0_busy_cycles", 32'(busy_cnt), 32'd6);

    // reps=0: single NULL cycle.
    clear_counts();
    step(1'b0, 1'b1, 5, 0);
    idle(2);
    check("reps0_busy_cycles", 32'(busy_cnt), 32'd1);
    check("reps0_done_pulses", 32'(done_cnt), 32'd1);

    // Start held through every busy cycle, including the final one.
    clear_counts();
    step(1'b0, 1'b1, 2, 2);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 7, 5);
    step(1'b0, 1'b0, 0, 0);
    check("busy_start_done_pulses", 32'(done_cnt), 32'd1);
    check("busy_start_busy_cycles", 32'(busy_cnt), 32'd10);
    step(1'b0, 1'b1, 1, 1);
    idle(5);

    // Reset during a FIRE cycle of frame 2.
    clear_counts();
    step(1'b0, 1'b1, 5, 3);
    idle(11);
    step(1'b1, 1'b0, 0, 0);
    idle(2);
    check("abort_done_pulses", 32'(done_cnt), 32'd0);
    clear_counts();
    step(1'b0, 1'b1, 5, 3);
    idle(25);
    check("restart_busy_cycles", 32'(busy_cnt), 32'd24);
    check("restart_done_pulses", 32'(done_cnt), 32'd1);

    // Longest transfer.
    step(1'b0, 1'b1, 15, 15);
    idle(272);

    // Random traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      int l, n;
      l = ($urandom_range(0, 9) == 0) ? 15 : $urandom_range(0, 5);
      n = $urandom_range(0, 4);
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 2) == 0), l, n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
